// File: rtl/md_pkg.sv
// Multiply/divide unit shared definitions.
// Op encodings, FSM states and default latencies.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    function automatic logic is_muldiv(logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_div(logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// E-stage to multiply/divide unit issue and result bundle.
// master = pipeline side, slave = md_ctrl side.
interface md_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_D;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, md_use_D,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, md_use_D,
        output busy, stall_req, hi, lo
    );

endinterface

// File: rtl/md_alu.sv
// Combinational mult/div datapath.
// Division works on magnitudes so INT_MIN / -1 needs no special case.
module md_alu
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div_zero
);

    logic        sgn;
    logic [63:0] prod;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        sgn  = (op == OP_MULT) || (op == OP_DIV);
        prod = {{32{sgn & a[31]}}, a} * {{32{sgn & b[31]}}, b};
        ma   = (sgn && a[31]) ? -a : a;
        mb   = (sgn && b[31]) ? -b : b;
        div_zero = (b == 32'd0);
        dv   = div_zero ? 32'd1 : mb;
        q    = ma / dv;
        r    = ma % dv;
        if (sgn && (a[31] ^ b[31])) q = -q;
        if (sgn && a[31]) r = -r;
        if (is_div(op)) begin
            hi_res = r;
            lo_res = q;
        end else begin
            hi_res = prod[63:32];
            lo_res = prod[31:0];
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: issue FSM, latency counter, HI/LO.
// Results are computed at accept and held pending until the count expires.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input logic clk,
    input logic reset,
    md_if.slave bus
);

    md_state_e   state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] hi_q, hi_n;
    logic [31:0] lo_q, lo_n;
    logic [31:0] ph, ph_n;
    logic [31:0] pl, pl_n;
    logic        pv, pv_n;

    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        alu_dz;
    logic        op_md;
    logic        op_mthi;
    logic        op_mtlo;

    md_alu u_alu (
        .op       (bus.op),
        .a        (bus.rs_val),
        .b        (bus.rt_val),
        .hi_res   (alu_hi),
        .lo_res   (alu_lo),
        .div_zero (alu_dz)
    );

    assign op_md   = is_muldiv(bus.op);
    assign op_mthi = (bus.op == OP_MTHI);
    assign op_mtlo = (bus.op == OP_MTLO);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hi_n    = hi_q;
        lo_n    = lo_q;
        ph_n    = ph;
        pl_n    = pl;
        pv_n    = pv;
        if (state == S_IDLE) begin
            if (bus.start) begin
                unique case (1'b1)
                    op_md: begin
                        ph_n    = alu_hi;
                        pl_n    = alu_lo;
                        // divide by zero burns the cycles but never commits
                        pv_n    = !(is_div(bus.op) && alu_dz);
                        cnt_n   = is_div(bus.op) ? 4'(DIV_LAT)
                                                 : 4'(MULT_LAT);
                        state_n = S_BUSY;
                    end
                    op_mthi: hi_n = bus.rs_val;
                    op_mtlo: lo_n = bus.rs_val;
                    default: ;
                endcase
            end
        end else begin
            cnt_n = cnt - 4'd1;
            if (cnt == 4'd1) begin
                state_n = S_IDLE;
                if (pv) begin
                    hi_n = ph;
                    lo_n = pl;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
            ph    <= 32'd0;
            pl    <= 32'd0;
            pv    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            ph    <= ph_n;
            pl    <= pl_n;
            pv    <= pv_n;
        end
    end

    assign bus.busy      = (state == S_BUSY);
    assign bus.stall_req = bus.md_use_D &
                           (bus.busy | (bus.start & op_md));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl.
// Expected HI/LO/latency come from a 64-bit reference model via a scoreboard.
module tb_md_ctrl;
    import md_pkg::*;

    localparam int ML = 5;
    localparam int DL = 10;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    md_if bus ();

    md_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        scb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] mhi = 32'd0;
    logic [31:0] mlo = 32'd0;

    function automatic exp_t model(logic [2:0] op, logic [31:0] a,
                                   logic [31:0] b, logic [31:0] oh,
                                   logic [31:0] ol);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        e.hi = oh;
        e.lo = ol;
        e.lat = 0;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            OP_MULT: begin
                q = sa * sbv;
                e.hi = q[63:32];
                e.lo = q[31:0];
                e.lat = ML;
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = ML;
            end
            OP_DIV: begin
                e.lat = DL;
                if (b != 32'd0) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            OP_DIVU: begin
                e.lat = DL;
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            OP_MTHI: e.hi = a;
            OP_MTLO: e.lo = a;
            default: ;
        endcase
        return e;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        scb.push_back(model(op, a, b, mhi, mlo));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        exp_t e;
        int   n;
        logic held;
        if (scb.size() == 0) begin
            total++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = scb.pop_front();
        n = 0;
        held = 1'b1;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 40) begin
            if (bus.hi !== mhi || bus.lo !== mlo) held = 1'b0;
            n++;
            @(negedge clk);
        end
        total++;
        if (n !== e.lat)
            $display("FAIL %s_lat: got %0d busy cycles, want %0d",
                     name, n, e.lat);
        else passed++;
        total++;
        if (!held)
            $display("FAIL %s_hold: hi/lo changed during busy", name);
        else passed++;
        total++;
        if (bus.hi !== e.hi || bus.lo !== e.lo)
            $display("FAIL %s_res: hi=%h lo=%h want hi=%h lo=%h",
                     name, bus.hi, bus.lo, e.hi, e.lo);
        else passed++;
        mhi = e.hi;
        mlo = e.lo;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.op = OP_MULT;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.md_use_D = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
            $display("FAIL reset_state: busy=%b hi=%h lo=%h want 0",
                     bus.busy, bus.hi, bus.lo);
        else passed++;
        total++;
        if (bus.stall_req !== 1'b0)
            $display("FAIL reset_stall_idle: got %b want 0", bus.stall_req);
        else passed++;
        bus.start = 1'b1;
        #1;
        total++;
        if (bus.stall_req !== 1'b1)
            $display("FAIL reset_stall_start: got %b want 1", bus.stall_req);
        else passed++;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0)
            $display("FAIL reset_no_accept: busy=%b want 0", bus.busy);
        else passed++;
        bus.start = 1'b0;
        bus.md_use_D = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_mult();
        issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        drain("mult_neg");
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        drain("multu");
        issue(OP_MULT, 32'h8000_0000, 32'h8000_0000);
        drain("mult_min");
        for (int i = 0; i < 3; i++) begin
            issue(OP_MULT, $urandom, $urandom);
            drain("mult_rnd");
            issue(OP_MULTU, $urandom, $urandom);
            drain("multu_rnd");
        end
    endtask

    task automatic test_div();
        issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        drain("div_neg");
        issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
        drain("divu_zero");
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        drain("div_ovf");
        issue(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE);
        drain("div_negdiv");
        issue(OP_DIV, 32'h1234_5678, 32'h0000_0000);
        drain("div_zero");
        for (int i = 0; i < 3; i++) begin
            issue(OP_DIV, $urandom, $urandom | 32'd1);
            drain("div_rnd");
            issue(OP_DIVU, $urandom, $urandom_range(1, 1000));
            drain("divu_rnd");
        end
    endtask

    task automatic test_move();
        issue(OP_MTHI, 32'h1234_5678, 32'hDEAD_BEEF);
        drain("mthi");
        issue(OP_MTLO, 32'hCAFE_F00D, 32'h0);
        drain("mtlo");
    endtask

    task automatic test_stall_ignore();
        exp_t e;
        int   n;
        logic bad;
        @(negedge clk);
        bus.md_use_D = 1'b1;
        bus.start = 1'b1;
        bus.op = OP_MULT;
        bus.rs_val = 32'd3;
        bus.rt_val = 32'hFFFF_FFFB;
        e = model(OP_MULT, 32'd3, 32'hFFFF_FFFB, mhi, mlo);
        #1;
        total++;
        if (bus.stall_req !== 1'b1)
            $display("FAIL stall_issue: got %b want 1", bus.stall_req);
        else passed++;
        @(posedge clk);
        #1;
        n = 0;
        bad = 1'b0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < 40) begin
            if (bus.stall_req !== 1'b1) bad = 1'b1;
            case (n)
                0: begin
                    bus.op = OP_DIV;
                    bus.rs_val = 32'd100;
                    bus.rt_val = 32'd7;
                end
                1: bus.op = OP_MTHI;
                2: bus.op = OP_MTLO;
                default: bus.start = 1'b0;
            endcase
            n++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        #1;
        total++;
        if (bad) $display("FAIL stall_busy: stall_req dropped while busy");
        else passed++;
        total++;
        if (n !== ML)
            $display("FAIL stall_lat: got %0d busy cycles, want %0d", n, ML);
        else passed++;
        total++;
        if (bus.stall_req !== 1'b0)
            $display("FAIL stall_after: got %b want 0", bus.stall_req);
        else passed++;
        total++;
        if (bus.hi !== e.hi || bus.lo !== e.lo)
            $display("FAIL ignore_busy: hi=%h lo=%h want hi=%h lo=%h",
                     bus.hi, bus.lo, e.hi, e.lo);
        else passed++;
        mhi = e.hi;
        mlo = e.lo;
        bus.md_use_D = 1'b0;
    endtask

    task automatic test_undef();
        @(negedge clk);
        bus.md_use_D = 1'b1;
        bus.start = 1'b1;
        bus.op = 3'd6;
        bus.rs_val = 32'h5555_AAAA;
        #1;
        total++;
        if (bus.stall_req !== 1'b0)
            $display("FAIL undef_stall: got %b want 0", bus.stall_req);
        else passed++;
        @(negedge clk);
        bus.op = 3'd7;
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_use_D = 1'b0;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== mhi || bus.lo !== mlo)
            $display("FAIL undef_state: busy=%b hi=%h lo=%h want 0 %h %h",
                     bus.busy, bus.hi, bus.lo, mhi, mlo);
        else passed++;
    endtask

    task automatic test_reset_mid();
        logic bad;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = OP_DIV;
        bus.rs_val = 32'd1000;
        bus.rt_val = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h want 0",
                     bus.busy, bus.hi, bus.lo);
        else passed++;
        @(negedge clk);
        reset = 1'b1;
        mhi = 32'd0;
        mlo = 32'd0;
        bad = 1'b0;
        repeat (DL + 2) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0)
                bad = 1'b1;
        end
        total++;
        if (bad) $display("FAIL reset_no_commit: state moved after reset");
        else passed++;
        issue(OP_MULT, 32'd6, 32'd7);
        drain("post_reset_mult");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_stall_ignore();
        test_undef();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
